// File: rtl/reg_file_wb.sv
// Write-back stage and register file for the 8-bit CPU: one-entry write-back
// register, NREGS x DATA_W array, two asynchronous read ports with forwarding.
module reg_file_wb #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int NREGS  = 8,
   parameter int BYPASS = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic              ZERO_IN,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic              ZERO_FLAG,
   output logic              PENDING
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] wb_addr;
   logic              wb_valid;
   logic              zero_flag;

   // Commit of the old entry and capture of the new one share the same edge,
   // so consecutive writes stream at one per cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         // NOTE: the array is reset here on purpose; the CPU expects every register to read zero after reset, which costs a clear on each flop.
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         wb_addr   <= '0;
         zero_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make commit read the pre-edge entry while capture loads the new one.
         if (wb_valid) begin
            regs[wb_addr] <= wb_data;
         end
         if (WRITE) begin
            wb_data   <= IN;
            wb_addr   <= INADDRESS;
            wb_valid  <= 1'b1;
            zero_flag <= ZERO_IN;
         end else begin
            wb_valid  <= 1'b0;
         end
      end
   end

   // An unknown write strobe is a bug upstream; the else-branch above drops it.
   write_known_a : assert property (@(posedge CLK) disable iff (RESET) !$isunknown(WRITE))
      else $error("reg_file_wb: WRITE is X/Z at posedge CLK");

   always_comb begin
      // NOTE: both outputs get a default first so no path through this block can infer a latch.
      OUT1 = regs[OUT1ADDRESS];
      OUT2 = regs[OUT2ADDRESS];
      if (BYPASS != 0 && wb_valid) begin
         if (wb_addr == OUT1ADDRESS) OUT1 = wb_data;
         if (wb_addr == OUT2ADDRESS) OUT2 = wb_data;
      end
   end

   assign ZERO_FLAG = zero_flag;
   assign PENDING   = wb_valid;

endmodule
